// File: rtl/mem_access_if.sv
// Wishbone pipelined bus bundle between the load/store unit and the bus fabric.
interface mem_access_if;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [31:0] i_wb_data;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic        i_wb_err;

  modport master (
    output o_wb_addr, o_wb_data, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
    input  i_wb_data, i_wb_ack, i_wb_stall, i_wb_err
  );

  modport slave (
    input  o_wb_addr, o_wb_data, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
    output i_wb_data, i_wb_ack, i_wb_stall, i_wb_err
  );
endinterface

// File: rtl/mem_access.sv
// Single-transaction load/store unit: one request per i_enable, one pipelined
// Wishbone access, aligned/sign-extended load result or an error pulse.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic [31:0] i_addr,
  input  logic        i_we,
  input  logic [31:0] i_value,
  input  logic [1:0]  i_data_width,
  input  logic        i_signed,
  output logic [31:0] o_value,
  output logic        o_completed,
  output logic        o_error,
  output logic        o_busy,
  mem_access_if.master wb
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q;
  logic [31:0] value_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] cnt_q;
  logic [3:0]  sel_q;
  logic [1:0]  off_q;
  logic [1:0]  width_q;
  logic        signed_q;
  logic        we_q;
  logic        cyc_q;
  logic        stb_q;
  logic        completed_q;
  logic        error_q;
  logic        busy_q;

  logic        req_bad;
  logic [3:0]  req_sel;
  logic [31:0] req_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic        bus_done;
  logic        bus_timeout;

  // Decode the incoming request: alignment check, lane enables, lane-replicated store data
  always_comb begin
    req_bad  = 1'b0;
    req_sel  = '0;
    req_data = i_value;
    case (i_data_width)
      2'b01: begin
        req_sel  = 4'b0001 << i_addr[1:0];
        req_data = {4{i_value[7:0]}};
      end
      2'b10: begin
        req_bad  = i_addr[0];
        req_sel  = i_addr[1] ? 4'b1100 : 4'b0011;
        req_data = {2{i_value[15:0]}};
      end
      2'b11: begin
        req_bad = |i_addr[1:0];
        req_sel = '1;
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Pick the addressed lane out of the read data and extend it to 32 bits
  always_comb begin
    ld_byte = wb.i_wb_data[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? wb.i_wb_data[31:16] : wb.i_wb_data[15:0];
    case (width_q)
      2'b01:   ld_value = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b10:   ld_value = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_value = wb.i_wb_data;
    endcase
  end

  // Termination conditions; the count is compared one ahead so the abort lands
  // on the edge where the counter would reach TIMEOUT
  always_comb begin
    bus_done    = ((state_q == REQ && !wb.i_wb_stall) || state_q == WAIT) &&
                  (wb.i_wb_ack || wb.i_wb_err);
    bus_timeout = (state_q != IDLE) && !bus_done && (cnt_q + 32'd1 == TIMEOUT);
  end

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      value_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      off_q       <= '0;
      width_q     <= '0;
      signed_q    <= 1'b0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      completed_q <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      completed_q <= 1'b0;
      error_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_enable) begin
            if (req_bad) begin
              error_q <= 1'b1;
            end else begin
              addr_q   <= {i_addr[31:2], 2'b00};
              data_q   <= req_data;
              sel_q    <= req_sel;
              we_q     <= i_we;
              off_q    <= i_addr[1:0];
              width_q  <= i_data_width;
              signed_q <= i_signed;
              cyc_q    <= 1'b1;
              stb_q    <= 1'b1;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              state_q  <= REQ;
            end
          end
        end
        default: begin
          if (bus_done || bus_timeout) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (bus_timeout || wb.i_wb_err) begin
              error_q <= 1'b1;
            end else begin
              completed_q <= 1'b1;
              if (!we_q) value_q <= ld_value;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
            if (state_q == REQ && !wb.i_wb_stall) begin
              stb_q   <= 1'b0;
              state_q <= WAIT;
            end
          end
        end
      endcase
    end
  end

  assign o_value      = value_q;
  assign o_completed  = completed_q;
  assign o_error      = error_q;
  assign o_busy       = busy_q;
  assign wb.o_wb_addr = addr_q;
  assign wb.o_wb_data = data_q;
  assign wb.o_wb_sel  = sel_q;
  assign wb.o_wb_we   = we_q;
  assign wb.o_wb_cyc  = cyc_q;
  assign wb.o_wb_stb  = stb_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table plus randomized transactions
// against a behavioural reference model, with a reactive Wishbone slave.
module tb_mem_access;
  localparam int unsigned TMO = 8;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] value;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] rdata;
    int          stall;  // stall cycles before the slave accepts
    int          dly;    // cycles from accept to response
    int          resp;   // 0 ack, 1 err, 2 ack+err, 3 never respond
  } req_t;

  typedef struct {
    logic        err;
    int          lat;    // cycle of the completion/error pulse (enable sampled in cycle 0)
    logic [31:0] val;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    req_t r;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        i_enable;
  logic [31:0] i_addr;
  logic        i_we;
  logic [31:0] i_value;
  logic [1:0]  i_data_width;
  logic        i_signed;
  logic [31:0] o_value;
  logic        o_completed;
  logic        o_error;
  logic        o_busy;

  mem_access_if wb ();

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_enable    (i_enable),
    .i_addr      (i_addr),
    .i_we        (i_we),
    .i_value     (i_value),
    .i_data_width(i_data_width),
    .i_signed    (i_signed),
    .o_value     (o_value),
    .o_completed (o_completed),
    .o_error     (o_error),
    .o_busy      (o_busy),
    .wb          (wb)
  );

  int          asserts = 0;
  int          fails   = 0;
  logic [31:0] model_val;
  vec_t        vecs[15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [31:0] value,
                              input logic [1:0] width, input logic sgn, input logic [31:0] rdata,
                              input int stall, input int dly, input int resp,
                              input logic err, input int lat, input logic [31:0] val,
                              input logic [3:0] sel, input logic [31:0] wdata);
    vec_t v;
    v.r.addr = addr; v.r.we = we; v.r.value = value; v.r.width = width; v.r.sgn = sgn;
    v.r.rdata = rdata; v.r.stall = stall; v.r.dly = dly; v.r.resp = resp;
    v.e.err = err; v.e.lat = lat; v.e.val = val; v.e.sel = sel; v.e.wdata = wdata;
    return v;
  endfunction

  // Reference: derive the outcome of one request from the access rules
  function automatic exp_t model(input req_t r, input logic [31:0] prev);
    exp_t        e;
    int          nb;
    int          off;
    int          rsp;
    logic [31:0] mask;
    logic [31:0] lane;
    nb  = (r.width == 2'd1) ? 1 : (r.width == 2'd2) ? 2 : (r.width == 2'd3) ? 4 : 0;
    off = int'(r.addr[1:0]);
    e.val = prev; e.sel = '0; e.wdata = '0; e.err = 1'b0; e.lat = 0;
    if (nb == 0 || (off % nb) != 0) begin
      e.err = 1'b1; e.lat = 1;
      return e;
    end
    e.sel = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = r.value[8*(i % nb) +: 8];
    rsp = 1 + r.stall + r.dly;
    if (r.resp == 3 || rsp > int'(TMO)) begin
      e.err = 1'b1; e.lat = int'(TMO) + 1;
      return e;
    end
    e.lat = rsp + 1;
    e.err = (r.resp != 0);
    if (!e.err && !r.we) begin
      mask = (nb == 4) ? 32'hffff_ffff : ((32'd1 << (8*nb)) - 32'd1);
      lane = (r.rdata >> (8*off)) & mask;
      if (r.sgn && lane[8*nb-1]) lane = lane | ~mask;
      e.val = lane;
    end
    return e;
  endfunction

  task automatic run_txn(input req_t r, input exp_t e, input bit mid_pulse, input string tag);
    bit          bad;
    bit          done;
    int          got_lat;
    logic        got_err;
    int          stall_left;
    int          wait_left;
    logic [31:0] addr0;
    bad = e.err && (e.lat == 1);
    done = 1'b0; got_lat = 0; got_err = 1'b0;
    stall_left = r.stall; wait_left = 0;
    @(negedge clk);
    i_enable = 1'b1; i_addr = r.addr; i_we = r.we; i_value = r.value;
    i_data_width = r.width; i_signed = r.sgn;
    wb.i_wb_ack = 1'b0; wb.i_wb_err = 1'b0; wb.i_wb_stall = 1'b0; wb.i_wb_data = r.rdata;
    @(negedge clk);
    i_enable = 1'b0;
    addr0 = wb.o_wb_addr;
    if (!bad) begin
      chk({tag, " busy c1"}, 32'(o_busy), 32'd1);
      chk({tag, " cyc c1"}, 32'(wb.o_wb_cyc), 32'd1);
      chk({tag, " stb c1"}, 32'(wb.o_wb_stb), 32'd1);
      chk({tag, " wb_addr"}, wb.o_wb_addr, r.addr & 32'hffff_fffc);
      chk({tag, " wb_sel"}, 32'(wb.o_wb_sel), 32'(e.sel));
      chk({tag, " wb_we"}, 32'(wb.o_wb_we), 32'(r.we));
      if (r.we) chk({tag, " wb_data"}, wb.o_wb_data, e.wdata);
    end else begin
      chk({tag, " cyc bad"}, 32'(wb.o_wb_cyc), 32'd0);
      chk({tag, " busy bad"}, 32'(o_busy), 32'd0);
    end
    for (int c = 1; c <= 40 && !done; c++) begin
      if (o_completed || o_error) begin
        done = 1'b1; got_lat = c; got_err = o_error;
      end else begin
        if (wb.o_wb_stb && c > 1) chk({tag, " addr stable"}, wb.o_wb_addr, addr0);
        wb.i_wb_ack = 1'b0; wb.i_wb_err = 1'b0; wb.i_wb_stall = 1'b0;
        if (wb.o_wb_cyc && wb.o_wb_stb) begin
          if (stall_left > 0) begin
            wb.i_wb_stall = 1'b1;
            stall_left--;
          end else if (r.resp != 3) begin
            if (r.dly == 0) begin
              wb.i_wb_ack = (r.resp != 1);
              wb.i_wb_err = (r.resp != 0);
            end else begin
              wait_left = r.dly;
            end
          end
        end else if (wb.o_wb_cyc && r.resp != 3) begin
          if (wait_left <= 1) begin
            wb.i_wb_ack = (r.resp != 1);
            wb.i_wb_err = (r.resp != 0);
          end else begin
            wait_left--;
          end
        end
        if (mid_pulse && c == 2) begin
          i_enable = 1'b1; i_addr = 32'h0000_0f00;
        end else begin
          i_enable = 1'b0;
        end
        @(negedge clk);
      end
    end
    wb.i_wb_ack = 1'b0; wb.i_wb_err = 1'b0; wb.i_wb_stall = 1'b0;
    i_enable = 1'b0;
    if (!done) begin
      asserts++; fails++;
      $display("FAIL %s pulse: none within 40 cycles, expected by cycle %0d", tag, e.lat);
    end else begin
      chk({tag, " kind(err)"}, 32'(got_err), 32'(e.err));
      chk({tag, " latency"}, 32'(got_lat), 32'(e.lat));
      chk({tag, " o_value"}, o_value, e.val);
      chk({tag, " busy at pulse"}, 32'(o_busy), 32'd0);
      chk({tag, " cyc at pulse"}, 32'(wb.o_wb_cyc), 32'd0);
    end
    if (mid_pulse) begin
      @(negedge clk);
      chk({tag, " dropped enable cyc"}, 32'(wb.o_wb_cyc), 32'd0);
      chk({tag, " dropped enable busy"}, 32'(o_busy), 32'd0);
    end
  endtask

  initial begin
    req_t r;
    exp_t e;
    bit   seen;
    int   x;

    vecs[0]  = mk(32'hb000_0004, 1'b0, 32'h0,        2'd3, 1'b0, 32'hdead_beef, 0, 0, 0, 1'b0, 2, 32'hdead_beef, 4'hf, 32'h0);
    vecs[1]  = mk(32'h0000_1003, 1'b1, 32'h0000_00a5, 2'd1, 1'b0, 32'h0,        0, 0, 0, 1'b0, 2, 32'hdead_beef, 4'h8, 32'ha5a5_a5a5);
    vecs[2]  = mk(32'h0000_2002, 1'b0, 32'h0,        2'd2, 1'b1, 32'h8001_1234, 0, 0, 0, 1'b0, 2, 32'hffff_8001, 4'hc, 32'h0);
    vecs[3]  = mk(32'h0000_2002, 1'b0, 32'h0,        2'd2, 1'b0, 32'h8001_1234, 0, 0, 0, 1'b0, 2, 32'h0000_8001, 4'hc, 32'h0);
    vecs[4]  = mk(32'h0000_3000, 1'b0, 32'h0,        2'd3, 1'b0, 32'h1234_5678, 3, 2, 0, 1'b0, 7, 32'h1234_5678, 4'hf, 32'h0);
    vecs[5]  = mk(32'h0000_1002, 1'b0, 32'h0,        2'd3, 1'b0, 32'h0,        0, 0, 0, 1'b1, 1, 32'h1234_5678, 4'h0, 32'h0);
    vecs[6]  = mk(32'h0000_4000, 1'b0, 32'h0,        2'd3, 1'b0, 32'h0,        0, 0, 3, 1'b1, 9, 32'h1234_5678, 4'hf, 32'h0);
    vecs[7]  = mk(32'h0000_4004, 1'b0, 32'h0,        2'd3, 1'b0, 32'h0,        0, 1, 1, 1'b1, 3, 32'h1234_5678, 4'hf, 32'h0);
    vecs[8]  = mk(32'h0000_5000, 1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        0, 0, 0, 1'b1, 1, 32'h1234_5678, 4'h0, 32'h0);
    vecs[9]  = mk(32'h0000_6001, 1'b0, 32'h0,        2'd1, 1'b1, 32'h0000_8000, 0, 0, 0, 1'b0, 2, 32'hffff_ff80, 4'h2, 32'h0);
    vecs[10] = mk(32'h0000_8000, 1'b0, 32'h0,        2'd3, 1'b0, 32'hcafe_f00d, 4, 3, 0, 1'b0, 9, 32'hcafe_f00d, 4'hf, 32'h0);
    vecs[11] = mk(32'h0000_8000, 1'b0, 32'h0,        2'd3, 1'b0, 32'h0,        4, 4, 0, 1'b1, 9, 32'hcafe_f00d, 4'hf, 32'h0);
    vecs[12] = mk(32'h0000_9002, 1'b1, 32'h0000_beef, 2'd2, 1'b0, 32'h0,        0, 0, 0, 1'b0, 2, 32'hcafe_f00d, 4'hc, 32'hbeef_beef);
    vecs[13] = mk(32'h0000_6003, 1'b0, 32'h0,        2'd1, 1'b0, 32'h9100_0000, 0, 0, 2, 1'b1, 2, 32'hcafe_f00d, 4'h8, 32'h0);
    vecs[14] = mk(32'h0000_a000, 1'b1, 32'h1122_3344, 2'd3, 1'b0, 32'h0,        1, 0, 0, 1'b0, 3, 32'hcafe_f00d, 4'hf, 32'h1122_3344);

    reset = 1'b0; i_enable = 1'b0; i_addr = '0; i_we = 1'b0; i_value = '0;
    i_data_width = '0; i_signed = 1'b0;
    wb.i_wb_data = '0; wb.i_wb_ack = 1'b0; wb.i_wb_stall = 1'b0; wb.i_wb_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset o_value", o_value, 32'h0);
    chk("reset pulses/busy", 32'({o_completed, o_error, o_busy}), 32'h0);
    chk("reset bus ctrl", 32'({wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we, wb.o_wb_sel}), 32'h0);
    chk("reset wb_addr", wb.o_wb_addr, 32'h0);
    chk("reset wb_data", wb.o_wb_data, 32'h0);
    reset = 1'b1;
    model_val = '0;

    for (int i = 0; i < 15; i++) begin
      run_txn(vecs[i].r, vecs[i].e, (i == 4), $sformatf("vec%0d", i));
      model_val = vecs[i].e.val;
    end

    for (int n = 0; n < 60; n++) begin
      r.addr  = $urandom;
      r.we    = 1'($urandom_range(0, 1));
      r.value = $urandom;
      r.width = 2'($urandom_range(0, 3));
      r.sgn   = 1'($urandom_range(0, 1));
      r.rdata = $urandom;
      r.stall = int'($urandom_range(0, 4));
      r.dly   = int'($urandom_range(0, 5));
      x       = int'($urandom_range(0, 9));
      r.resp  = (x <= 6) ? 0 : x - 6;
      e = model(r, model_val);
      run_txn(r, e, 1'b0, $sformatf("rnd%0d", n));
      model_val = e.val;
    end

    // Reset asserted while the slave is holding the transaction in WAIT
    @(negedge clk);
    i_enable = 1'b1; i_addr = 32'h0000_c000; i_we = 1'b0; i_data_width = 2'd3;
    @(negedge clk);
    i_enable = 1'b0;
    @(negedge clk);
    chk("rstwait cyc before", 32'(wb.o_wb_cyc), 32'd1);
    chk("rstwait stb before", 32'(wb.o_wb_stb), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstwait cyc", 32'(wb.o_wb_cyc), 32'd0);
    chk("rstwait busy", 32'(o_busy), 32'd0);
    chk("rstwait pulses", 32'({o_completed, o_error}), 32'd0);
    chk("rstwait o_value", o_value, 32'h0);
    reset = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (o_completed || o_error || wb.o_wb_cyc) seen = 1'b1;
    end
    chk("rstwait no later activity", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
